// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - opcode and FSM state encodings for iter_shift_unit
// Optional feature macro used by the bundle: SHIFT_ROTATE_EN
package shift_pkg;

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_SRA  = 2'b10;
  localparam logic [1:0] OP_ROTR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/iter_shift_unit_if.sv
// rtl/iter_shift_unit_if.sv - request/response bundle between EX stage and iter_shift_unit
// master = pipeline side, slave = shift unit
interface iter_shift_unit_if #(
  parameter int WIDTH = 32
);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             busy;

  modport master (
    output flush, in_valid, op, X, Y, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  flush, in_valid, op, X, Y, out_ready,
    output in_ready, out_valid, result, busy
  );

endinterface

// File: rtl/shift_step.sv
// rtl/shift_step.sv - one-bit shift of the accumulator for the selected op
// SHIFT_ROTATE_EN enables ROTR on op 11; otherwise op 11 behaves as SRL
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [1:0]       op_i,
  output logic [WIDTH-1:0] acc_o
);

  always_comb begin
    acc_o = {1'b0, acc_i[WIDTH-1:1]};
    case (op_i)
      OP_SLL:  acc_o = {acc_i[WIDTH-2:0], 1'b0};
      OP_SRA:  acc_o = {acc_i[WIDTH-1], acc_i[WIDTH-1:1]};
`ifdef SHIFT_ROTATE_EN
      OP_ROTR: acc_o = {acc_i[0], acc_i[WIDTH-1:1]};
`endif
      default: acc_o = {1'b0, acc_i[WIDTH-1:1]};
    endcase
  end

endmodule

// File: rtl/iter_shift_unit.sv
// rtl/iter_shift_unit.sv - bit-serial shifter: accept, shift one bit per cycle, hold result
// Rotate support selected by SHIFT_ROTATE_EN inside shift_step
module iter_shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  iter_shift_unit_if.slave   bus
);

  localparam logic [SHAMT_W-1:0] CNT_ONE = {{(SHAMT_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   acc_step;
  logic               accept;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .acc_i (acc_q),
    .op_i  (op_q),
    .acc_o (acc_step)
  );

  assign accept = bus.in_valid && (state_q == ST_IDLE) && !bus.flush;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    // flush squashes everything, including a same-cycle request
    if (bus.flush) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            acc_d   = bus.X;
            cnt_d   = bus.Y[SHAMT_W-1:0];
            op_d    = bus.op;
            state_d = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (cnt_q == '0) begin
            state_d = ST_DONE;
          end else begin
            acc_d = acc_step;
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.result    = acc_q;

endmodule
